// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard/stall controller and its detect logic.
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_FLUSH   = 2'd2,
        S_FWAIT   = 2'd3
    } state_e;

    localparam int unsigned REG_ZERO = 0;

    localparam int unsigned REG_W_DEF               = 5;
    localparam int unsigned LOAD_USE_STALLS_DEF     = 1;
    localparam int unsigned BRANCH_FLUSH_CYCLES_DEF = 1;
    localparam int unsigned FETCH_TIMEOUT_DEF       = 15;

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_MAX = 8'hFF;

    // The detection cycle is cycle 1, so the counter covers the remaining cycles minus one.
    function automatic logic [CNT_W-1:0] cnt_init(input int unsigned cycles);
        if (cycles > 1) begin
            return CNT_W'(cycles - 2);
        end
        return '0;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and taken-branch/jump detection for the ID stage.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    output logic             lu,
    output logic             br
);

    logic rs_match;
    logic rt_match;
    logic dest_nonzero;

    always_comb begin
        rs_match     = (idex_rt == ifid_rs);
        rt_match     = id_uses_rt & (idex_rt == ifid_rt);
        // Loads to the zero register never create a real dependency.
        dest_nonzero = (idex_rt != REG_W'(REG_ZERO));
        lu           = idex_memread & dest_nonzero & (rs_match | rt_match);
        br           = id_branch_taken | id_jump;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller sequencing the PC and IF/ID register.
// Optional perf counters (stall_cycles, flush_cycles) enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W               = REG_W_DEF,
    parameter int unsigned LOAD_USE_STALLS     = LOAD_USE_STALLS_DEF,
    parameter int unsigned BRANCH_FLUSH_CYCLES = BRANCH_FLUSH_CYCLES_DEF,
    parameter int unsigned FETCH_TIMEOUT       = FETCH_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             if_flush,
    output logic             id_bubble,
    output logic             fetch_timeout,
    output logic             busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_cycles
`endif
);

    localparam logic [CNT_W-1:0]  LU_INIT    = cnt_init(LOAD_USE_STALLS);
    localparam logic [CNT_W-1:0]  BR_INIT    = cnt_init(BRANCH_FLUSH_CYCLES);
    localparam logic [WAIT_W-1:0] TIMEOUT_AT = WAIT_W'(FETCH_TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    logic lu;
    logic br;
    logic pc_write_raw;
    logic ifid_write_raw;
    logic if_flush_raw;
    logic id_bubble_raw;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .id_uses_rt      (id_uses_rt),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .id_branch_taken (id_branch_taken),
        .id_jump         (id_jump),
        .lu              (lu),
        .br              (br)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_d      = timeout_q;
        pc_write_raw   = 1'b0;
        ifid_write_raw = 1'b0;
        if_flush_raw   = 1'b0;
        id_bubble_raw  = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (lu) begin
                    id_bubble_raw = 1'b1;
                    if (LOAD_USE_STALLS > 1) begin
                        state_d = S_LDSTALL;
                        cnt_d   = LU_INIT;
                    end
                end else if (br) begin
                    pc_write_raw = 1'b1;
                    if_flush_raw = 1'b1;
                    if (BRANCH_FLUSH_CYCLES > 1) begin
                        state_d = S_FLUSH;
                        cnt_d   = BR_INIT;
                    end
                end else if (!imem_ready) begin
                    if_flush_raw = 1'b1;
                    state_d      = S_FWAIT;
                    wait_cnt_d   = WAIT_W'(1);
                end else begin
                    pc_write_raw   = 1'b1;
                    ifid_write_raw = 1'b1;
                end
            end
            // IF/ID is held, so a branch seen here is picked up again back in S_RUN.
            S_LDSTALL: begin
                id_bubble_raw = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FLUSH: begin
                pc_write_raw = 1'b1;
                if_flush_raw = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // The word arriving with imem_ready is captured by the next S_RUN cycle.
            S_FWAIT: begin
                if_flush_raw = 1'b1;
                if (imem_ready) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if ((state_d == S_FWAIT) && (wait_cnt_d == TIMEOUT_AT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // S_RUN outputs are Mealy, so they are gated to hold everything quiet during reset.
    always_comb begin
        pc_write      = reset & pc_write_raw;
        ifid_write    = reset & ifid_write_raw;
        if_flush      = reset & if_flush_raw;
        id_bubble     = reset & id_bubble_raw;
        fetch_timeout = timeout_q;
        busy          = reset & (state_q != S_RUN);
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_cycles_q;
    logic        stall_active;
    logic        flush_active;

    always_comb begin
        stall_active = id_bubble | (if_flush & ~pc_write);
        flush_active = if_flush & pc_write;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            if (stall_active && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush_active && (flush_cycles_q != 32'hFFFF_FFFF)) begin
                flush_cycles_q <= flush_cycles_q + 32'd1;
            end
        end
    end

    always_comb begin
        stall_cycles = stall_cycles_q;
        flush_cycles = flush_cycles_q;
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controller configurations driven in lockstep with directed vectors.
module tb_hazard_stall_ctrl;

    localparam int unsigned REG_W = 5;

    // Expected vector bit order: {pc_write, ifid_write, if_flush, id_bubble, busy, fetch_timeout}
    localparam logic [5:0] E_RST  = 6'b000000;
    localparam logic [5:0] E_NRM  = 6'b110000;
    localparam logic [5:0] E_LU   = 6'b000100;
    localparam logic [5:0] E_LDS  = 6'b000110;
    localparam logic [5:0] E_BR   = 6'b101000;
    localparam logic [5:0] E_FLS  = 6'b101010;
    localparam logic [5:0] E_FW0  = 6'b001000;
    localparam logic [5:0] E_FW   = 6'b001010;
    localparam logic [5:0] E_TO   = 6'b000001;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             id_uses_rt;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic             id_branch_taken;
    logic             id_jump;
    logic             imem_ready;

    logic pc_write_a, ifid_write_a, if_flush_a, id_bubble_a, fetch_timeout_a, busy_a;
    logic pc_write_b, ifid_write_b, if_flush_b, id_bubble_b, fetch_timeout_b, busy_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_a, flush_cycles_a, stall_cycles_b, flush_cycles_b;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [11:0] exp_q[$];
    string       name_q[$];
    bit          stim_done = 1'b0;

    // Config A: single-cycle load-use stall, two-cycle flush.
    hazard_stall_ctrl #(
        .REG_W               (REG_W),
        .LOAD_USE_STALLS     (1),
        .BRANCH_FLUSH_CYCLES (2),
        .FETCH_TIMEOUT       (15)
    ) dut_a (
        .clk             (clk),
        .reset           (reset),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .id_uses_rt      (id_uses_rt),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .id_branch_taken (id_branch_taken),
        .id_jump         (id_jump),
        .imem_ready      (imem_ready),
        .pc_write        (pc_write_a),
        .ifid_write      (ifid_write_a),
        .if_flush        (if_flush_a),
        .id_bubble       (id_bubble_a),
        .fetch_timeout   (fetch_timeout_a),
        .busy            (busy_a)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles_a),
        .flush_cycles    (flush_cycles_a)
`endif
    );

    // Config B: four-cycle load-use stall, single-cycle flush.
    hazard_stall_ctrl #(
        .REG_W               (REG_W),
        .LOAD_USE_STALLS     (4),
        .BRANCH_FLUSH_CYCLES (1),
        .FETCH_TIMEOUT       (15)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .id_uses_rt      (id_uses_rt),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .id_branch_taken (id_branch_taken),
        .id_jump         (id_jump),
        .imem_ready      (imem_ready),
        .pc_write        (pc_write_b),
        .ifid_write      (ifid_write_b),
        .if_flush        (if_flush_b),
        .id_bubble       (id_bubble_b),
        .fetch_timeout   (fetch_timeout_b),
        .busy            (busy_b)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles_b),
        .flush_cycles    (flush_cycles_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic mr, input logic [REG_W-1:0] irt,
                        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic urt, input logic bt, input logic jmp, input logic rdy,
                        input logic [5:0] ea, input logic [5:0] eb, input string nm);
        @(posedge clk);
        #1;
        reset           = rst;
        idex_memread    = mr;
        idex_rt         = irt;
        ifid_rs         = rs;
        ifid_rt         = rt;
        id_uses_rt      = urt;
        id_branch_taken = bt;
        id_jump         = jmp;
        imem_ready      = rdy;
        exp_q.push_back({ea, eb});
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n, input logic [5:0] ea, input logic [5:0] eb,
                        input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, ea, eb, nm);
        end
    endtask

    task automatic loaduse(input logic [5:0] ea, input logic [5:0] eb, input string nm);
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, ea, eb, nm);
    endtask

    task automatic jump(input logic [5:0] ea, input logic [5:0] eb, input string nm);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ea, eb, nm);
    endtask

    task automatic nofetch(input int n, input logic [5:0] ea, input logic [5:0] eb,
                           input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, nm);
        end
    endtask

    // Monitor: every cycle is an output beat; compare whatever stimulus has queued.
    initial begin
        logic [11:0] e;
        logic [5:0]  act_a, act_b;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_a = {pc_write_a, ifid_write_a, if_flush_a, id_bubble_a, busy_a,
                         fetch_timeout_a};
                act_b = {pc_write_b, ifid_write_b, if_flush_b, id_bubble_b, busy_b,
                         fetch_timeout_b};
                checks++;
                if (act_a !== e[11:6]) begin
                    errors++;
                    $display("FAIL %s cfgA: got %b expected %b", nm, act_a, e[11:6]);
                end
                checks++;
                if (act_b !== e[5:0]) begin
                    errors++;
                    $display("FAIL %s cfgB: got %b expected %b", nm, act_b, e[5:0]);
                end
            end
        end
    end

    initial begin
        reset           = 1'b0;
        idex_memread    = 1'b0;
        idex_rt         = '0;
        ifid_rs         = '0;
        ifid_rt         = '0;
        id_uses_rt      = 1'b0;
        id_branch_taken = 1'b0;
        id_jump         = 1'b0;
        imem_ready      = 1'b1;

        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_RST, E_RST, "reset");
        idle(1, E_NRM, E_NRM, "idle");

        // Load-use on rs: A stalls one cycle, B four.
        loaduse(E_LU, E_LU, "lu_rs");
        idle(3, E_NRM, E_LDS, "lu_rs_hold");
        idle(1, E_NRM, E_NRM, "lu_rs_done");

        // rt gating and zero-register filter.
        step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_NRM, E_NRM, "lu_r0");
        step(1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, E_NRM, E_NRM, "rt_unused");
        step(1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, E_LU, E_LU, "rt_used");
        idle(3, E_NRM, E_LDS, "rt_hold");
        idle(1, E_NRM, E_NRM, "rt_done");

        // Taken branch: A flushes two cycles, B one.
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_BR, E_BR, "br");
        idle(1, E_FLS, E_NRM, "br_second");
        idle(1, E_NRM, E_NRM, "br_done");

        // Load-use together with jump: stall first, flush once lu clears.
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_LU, E_LU, "lu_jmp");
        jump(E_BR, E_LDS, "jmp_after_lu");
        jump(E_FLS, E_LDS, "jmp_defer1");
        jump(E_BR, E_LDS, "jmp_defer2");
        jump(E_FLS, E_BR, "jmp_resume");
        idle(1, E_NRM, E_NRM, "jmp_done");

        // Short fetch wait, with a load-use arriving on the ready cycle.
        nofetch(1, E_FW0, E_FW0, "fw_enter");
        nofetch(2, E_FW, E_FW, "fw_hold");
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_FW, E_FW, "fw_ready_lu");
        loaduse(E_LU, E_LU, "fw_lu_resume");
        idle(3, E_NRM, E_LDS, "fw_lu_hold");
        idle(1, E_NRM, E_NRM, "fw_lu_done");

        // Fifteen not-ready cycles trip the sticky timeout.
        nofetch(1, E_FW0, E_FW0, "to_enter");
        nofetch(14, E_FW, E_FW, "to_wait");
        idle(1, E_FW | E_TO, E_FW | E_TO, "to_ready");
        idle(2, E_NRM | E_TO, E_NRM | E_TO, "to_sticky");

        // Reset in the second cycle of B's load-use stall.
        loaduse(E_LU | E_TO, E_LU | E_TO, "mid_lu");
        idle(1, E_NRM | E_TO, E_LDS | E_TO, "mid_lu_hold");
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_RST, E_RST, "mid_reset");
        idle(2, E_NRM, E_NRM, "post_reset");

        stim_done = 1'b1;
    end

    initial begin
        int unsigned budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Hazard and stall controller that sequences the IF/ID pipeline register and the PC.
- Detects load-use hazards, taken branches/jumps in ID, and instruction-memory wait states.
- Drives ifid_write, if_flush, pc_write, and an ID/EX bubble select, each for a counted number of cycles.
- Sits between the ID-stage decode/compare logic and the IF-stage registers; keeps a sticky fetch-timeout error flag.

Parameters:
- REG_W, 5, register-specifier width.
- LOAD_USE_STALLS, 1, stall cycles per load-use hazard (1..7).
- BRANCH_FLUSH_CYCLES, 1, flush cycles per taken branch/jump (1..7).
- FETCH_TIMEOUT, 15, consecutive imem-not-ready cycles before fetch_timeout is set (1..255).

Ports:
- clk  in  1  system clock; state updates on posedge (IF/ID samples on negedge, so outputs settle half a cycle ahead).
- reset  in  1  asynchronous, active-low reset.
- ifid_rs  in  REG_W  rs field of the instruction in ID.
- ifid_rt  in  REG_W  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  REG_W  load destination register in EX.
- id_branch_taken  in  1  branch resolved taken in ID.
- id_jump  in  1  jump in ID.
- imem_ready  in  1  instruction memory returned valid data this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID write enable.
- if_flush  out  1  zero the IF/ID contents.
- id_bubble  out  1  force zero control into ID/EX.
- fetch_timeout  out  1  sticky error flag.
- busy  out  1  FSM not in S_RUN.

Behaviour:
- Reset (reset=0, async):
  - state=S_RUN, cnt=0, wait_cnt=0, fetch_timeout=0.
  - Outputs while reset is asserted: pc_write=0, ifid_write=0, if_flush=0, id_bubble=0, busy=0.
- Hazard terms:
  - lu = idex_memread & (idex_rt!=0) & ((idex_rt==ifid_rs) | (id_uses_rt & idex_rt==ifid_rt)).
  - br = id_branch_taken | id_jump.
- States: S_RUN, S_LDSTALL, S_FLUSH, S_FWAIT. 3-bit down-counter cnt.
- Outputs are Mealy in S_RUN and Moore elsewhere. The detection cycle counts as cycle 1 of any stall or flush.
- S_RUN priority is lu > br > !imem_ready > normal:
  - lu: pc_write=0, ifid_write=0, if_flush=0, id_bubble=1. If LOAD_USE_STALLS>1: go to S_LDSTALL with cnt=LOAD_USE_STALLS-2. Otherwise stay in S_RUN.
  - br (no lu): pc_write=1, ifid_write=0, if_flush=1, id_bubble=0. If BRANCH_FLUSH_CYCLES>1: go to S_FLUSH with cnt=BRANCH_FLUSH_CYCLES-2.
  - !imem_ready: pc_write=0, ifid_write=0, if_flush=1, id_bubble=0. Go to S_FWAIT with wait_cnt=1.
  - normal: pc_write=1, ifid_write=1, all other outputs 0.
- S_LDSTALL:
  - Outputs as the lu case.
  - cnt==0: go to S_RUN. Otherwise decrement cnt.
  - A branch arriving in ID during the stall is deferred; it is re-evaluated in S_RUN because IF/ID is held.
- S_FLUSH:
  - Outputs as the br case.
  - cnt==0: go to S_RUN. Otherwise decrement cnt.
  - imem_ready is ignored while flushing.
- S_FWAIT:
  - Outputs as the !imem_ready case.
  - imem_ready=1: go to S_RUN and clear wait_cnt. That cycle's outputs are still FWAIT outputs; the fetched word is captured in the following S_RUN cycle.
  - Otherwise wait_cnt increments, saturating at 255.
  - When wait_cnt reaches FETCH_TIMEOUT, fetch_timeout=1. It stays set until reset.
  - lu or br arriving during S_FWAIT is evaluated on return to S_RUN.
- Never assert ifid_write and if_flush together.
- busy = (state != S_RUN).
- Reset mid-stall returns to S_RUN immediately; no partial counts are retained.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_cycles[31:0], both reset to 0.
  - stall_cycles increments every cycle id_bubble=1 or FWAIT outputs are active.
  - flush_cycles increments every cycle br-case outputs are active.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - State encoding typedef: S_RUN=0, S_LDSTALL=1, S_FLUSH=2, S_FWAIT=3.
  - Constant REG_ZERO.
  - Default parameter constants.
- One natural sub-module, hazard_detect: the purely combinational lu/br computation, reused by the forwarding unit.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5, LOAD_USE_STALLS=1 -> exactly one cycle with pc_write=0, ifid_write=0, id_bubble=1, busy=0; next cycle normal.
- rt gating: idex_rt=0 with ifid_rs=0 -> no stall. Then idex_rt=7, ifid_rt=7, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
- Branch with BRANCH_FLUSH_CYCLES=2: id_branch_taken=1 for one cycle -> if_flush=1, pc_write=1 for 2 cycles, busy=1 during the second.
- Simultaneous: lu=1 and id_jump=1 -> stall cycle first (if_flush=0), then flush cycle once lu clears.
- Fetch wait: imem_ready=0 for 3 cycles with FETCH_TIMEOUT=15 -> 3 cycles of pc_write=0, if_flush=1; fetch_timeout stays 0. Hold low 15 cycles -> fetch_timeout=1, sticky after imem_ready=1.
- Reset asserted mid-S_LDSTALL (LOAD_USE_STALLS=4, 2nd cycle) -> outputs 0, state S_RUN; after release, normal run with busy=0.
